// File: rtl/pll_phase_seq_pkg.sv
// pll_phase_seq_pkg: sequencer states, PLL output-select codes and default timing.
package pll_phase_seq_pkg;
    typedef enum logic [2:0] {LOCK_WAIT, READY, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI} state_t;
    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;
    localparam int LOCK_CYCLES_DEF   = 1024;
    localparam int SETUP_CYCLES_DEF  = 4;
    localparam int PULSE_CYCLES_DEF  = 4;
    localparam int SETTLE_CYCLES_DEF = 8;
    localparam int STEP_W_DEF        = 6;
endpackage

// File: rtl/pll_phase_seq_lock_sync_filter.sv
// lock_sync_filter: 2-flop PLL lock synchroniser plus stable-lock cycle qualifier.
module lock_sync_filter #(
    parameter int LOCK_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic i_lock,
    input  logic i_en,
    output logic o_lk_s,
    output logic o_ok
);
    localparam int CW = $clog2(LOCK_CYCLES);
    logic r_s1;
    logic r_s2;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_lock;
            r_s2  <= r_s1;
            r_cnt <= (i_en && r_s2) ? r_cnt + CW'(1) : '0;
        end
    end
    assign o_lk_s = r_s2;
    assign o_ok   = i_en && r_s2 && (r_cnt == CW'(LOCK_CYCLES - 1));
endmodule

// File: rtl/pll_phase_seq.sv
// pll_phase_seq: ECP5 EHXPLLL lock-qualified reset release and dynamic phase stepping.
// Optional per-output net phase counters on phase_pos when PLL_PHASE_SEQ_POS_EN is defined.
module pll_phase_seq
    import pll_phase_seq_pkg::*;
#(
    parameter int LOCK_CYCLES   = LOCK_CYCLES_DEF,
    parameter int SETUP_CYCLES  = SETUP_CYCLES_DEF,
    parameter int PULSE_CYCLES  = PULSE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int STEP_W        = STEP_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              done,
    output logic              done_err,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              phaseloadreg,
    output logic              sys_reset,
`ifdef PLL_PHASE_SEQ_POS_EN
    output logic [31:0]       phase_pos,
`endif
    output logic              lock_lost
);
    state_t r_state;
    state_t w_next;
    logic [15:0] r_tcnt;
    logic [15:0] w_lim;
    logic [STEP_W-1:0] r_steps;
    logic [1:0] r_sel;
    logic r_dir;
    logic r_done;
    logic r_err;
    logic r_lost;
    logic w_lk_s;
    logic w_lock_ok;
    logic w_last;
    logic w_busy;
    logic w_loss;

    lock_sync_filter #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock (
        .clock (clock),
        .reset (reset),
        .i_lock(pll_locked),
        .i_en  (r_state == LOCK_WAIT),
        .o_lk_s(w_lk_s),
        .o_ok  (w_lock_ok)
    );

    // One shared phase timer; its terminal count depends on the phase being timed.
    assign w_lim  = (r_state == SETUP) ? 16'(SETUP_CYCLES - 1) :
                    (r_state == STEP_LO || r_state == LOAD_LO) ? 16'(PULSE_CYCLES - 1) :
                    16'(SETTLE_CYCLES - 1);
    assign w_last = r_tcnt == w_lim;
    assign w_busy = r_state != LOCK_WAIT && r_state != READY;
    assign w_loss = r_state != LOCK_WAIT && !w_lk_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= LOCK_WAIT;
            r_tcnt  <= '0;
            r_steps <= '0;
            r_sel   <= SEL_CLKOP;
            r_dir   <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tcnt  <= (w_next != r_state || !w_busy) ? '0 : r_tcnt + 16'd1;
            if (r_state == READY && w_next == SETUP) begin
                r_sel   <= req_sel;
                r_dir   <= req_dir;
                r_steps <= req_steps;
            end
            if (r_state == STEP_HI && w_last) r_steps <= r_steps - STEP_W'(1);
            r_done <= w_busy && (w_loss || (r_state == LOAD_HI && w_last));
            r_err  <= w_busy && w_loss;
            r_lost <= r_lost | w_loss;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOCK_WAIT: w_next = w_lock_ok ? READY : LOCK_WAIT;
            READY:     w_next = req_valid ? SETUP : READY;
            SETUP:     if (w_last) w_next = (r_steps == '0) ? LOAD_LO : STEP_LO;
            STEP_LO:   if (w_last) w_next = STEP_HI;
            STEP_HI:   if (w_last) w_next = (r_steps == STEP_W'(1)) ? LOAD_LO : STEP_LO;
            LOAD_LO:   if (w_last) w_next = LOAD_HI;
            LOAD_HI:   if (w_last) w_next = READY;
            default:   w_next = LOCK_WAIT;
        endcase
        if (w_loss) w_next = LOCK_WAIT;
    end

    always_comb begin
        req_ready    = r_state == READY;
        sys_reset    = r_state == LOCK_WAIT;
        phasestep    = r_state != STEP_LO;
        phaseloadreg = r_state != LOAD_LO;
        phasesel     = r_sel;
        phasedir     = r_dir;
        done         = r_done;
        done_err     = r_err;
        lock_lost    = r_lost;
    end

`ifdef PLL_PHASE_SEQ_POS_EN
    logic [31:0] r_pos;
    // Counted at the end of each settle, so steps finished before an abort stay counted.
    always_ff @(posedge clock) begin
        if (reset) r_pos <= '0;
        else if (r_state == STEP_HI && w_last)
            r_pos[{r_sel, 3'b000} +: 8] <= r_pos[{r_sel, 3'b000} +: 8] + (r_dir ? 8'd1 : 8'hFF);
    end
    assign phase_pos = r_pos;
`endif
endmodule

// File: tb/tb_pll_phase_seq.sv
// tb_pll_phase_seq: scoreboard bench for lock qualification, phase stepping and lock-loss abort.
module tb_pll_phase_seq;
    localparam int LOCK   = 1024;
    localparam int SETUP  = 4;
    localparam int PULSE  = 4;
    localparam int SETTLE = 8;

    typedef struct {
        logic err;
        int   lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pll_locked = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [1:0] req_sel = 2'd0;
    logic req_dir = 1'b0;
    logic [5:0] req_steps = 6'd0;
    logic done;
    logic done_err;
    logic [1:0] phasesel;
    logic phasedir;
    logic phasestep;
    logic phaseloadreg;
    logic sys_reset;
    logic lock_lost;
`ifdef PLL_PHASE_SEQ_POS_EN
    logic [31:0] phase_pos;
`endif

    int n_chk = 0;
    int n_err = 0;
    exp_t sb[$];
    int step_w[$];
    int load_w[$];
    int sr = 0;
    int lr = 0;
    bit bad_sel = 0;
    bit seen_done = 0;
    logic [1:0] e_sel = 2'd0;
    logic e_dir = 1'b1;

    pll_phase_seq dut (
        .clock       (clock),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dir     (req_dir),
        .req_steps   (req_steps),
        .done        (done),
        .done_err    (done_err),
        .phasesel    (phasesel),
        .phasedir    (phasedir),
        .phasestep   (phasestep),
        .phaseloadreg(phaseloadreg),
        .sys_reset   (sys_reset),
`ifdef PLL_PHASE_SEQ_POS_EN
        .phase_pos   (phase_pos),
`endif
        .lock_lost   (lock_lost)
    );

    initial forever #20 clock = ~clock;

    always @(negedge clock) begin
        if (!phasestep) sr++;
        else if (sr != 0) begin
            step_w.push_back(sr);
            sr = 0;
        end
        if (!phaseloadreg) lr++;
        else if (lr != 0) begin
            load_w.push_back(lr);
            lr = 0;
        end
        if (!sys_reset && !req_ready && (phasesel != e_sel || phasedir != e_dir)) bad_sel = 1;
        if (done) seen_done = 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int st);
        return 1 + SETUP + st * (PULSE + SETTLE) + PULSE + SETTLE;
    endfunction

    // Caller is just past a negedge; the next posedge is the first high lock sample.
    task automatic lock_up(input string tag);
        int n = 0;
        pll_locked = 1'b1;
        while (n < 3000) begin
            @(posedge clock);
            n++;
            #1;
            if (!sys_reset) break;
        end
        chk(tag, n, LOCK + 2);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] sel, input logic dir, input int steps, input bit drop);
        exp_t e;
        int n = 0;
        int bad_w = 0;
        bit seen = 0;
        // Lock dropped after the 18th edge reaches lk_s two edges later, mid 2nd STEP_LO.
        e.err = drop;
        e.lat = drop ? 21 : exp_lat(steps);
        @(negedge clock);
        step_w.delete();
        load_w.delete();
        bad_sel = 0;
        e_sel = sel;
        e_dir = dir;
        req_sel = sel;
        req_dir = dir;
        req_steps = 6'(steps);
        req_valid = 1'b1;
        sb.push_back(e);
        while (n < e.lat + 50 && !seen) begin
            @(posedge clock);
            n++;
            #1;
            req_valid = 1'b0;
            if (drop && n == 18) pll_locked = 1'b0;
            seen = done;
        end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("done_err", done_err, e.err);
        if (!drop) begin
            foreach (step_w[i]) if (step_w[i] != PULSE) bad_w++;
            foreach (load_w[i]) if (load_w[i] != PULSE) bad_w++;
            chk("step_pulses", step_w.size(), steps);
            chk("load_pulses", load_w.size(), 1);
            chk("pulse_width", bad_w, 0);
            chk("phasesel", phasesel, sel);
            chk("phasedir", phasedir, dir);
            chk("sel_stable", bad_sel, 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_phasestep", phasestep, 1);
        chk("rst_phaseloadreg", phaseloadreg, 1);
        chk("rst_phasesel", phasesel, 0);
        chk("rst_phasedir", phasedir, 1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_lock_lost", lock_lost, 0);
        @(negedge clock);
        lock_up("lock_release");
        chk("lock_lost_clean", lock_lost, 0);
        chk("ready_after_lock", req_ready, 1);

        do_req(2'd2, 1'b1, 3, 0);
        do_req(2'd0, 1'b0, 0, 0);
        do_req(2'd3, 1'b0, 63, 0);
        do_req(2'd1, 1'b1, 3, 1);
        chk("loss_lock_lost", lock_lost, 1);
        chk("loss_sys_reset", sys_reset, 1);
        chk("loss_phasestep", phasestep, 1);
        chk("loss_req_ready", req_ready, 0);
        @(negedge clock);
        lock_up("relock_release");
        chk("lock_lost_sticky", lock_lost, 1);

        @(negedge clock);
        req_sel = 2'd1;
        req_dir = 1'b0;
        req_steps = 6'd5;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen_done = 0;
        @(posedge clock);
        #1;
        chk("midrst_sys_reset", sys_reset, 1);
        chk("midrst_phasestep", phasestep, 1);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_lock_lost", lock_lost, 0);
        chk("midrst_phasesel", phasesel, 0);
        @(negedge clock);
        reset = 1'b0;
        lock_up("midrst_release");
        chk("midrst_no_done", seen_done, 0);

        do_reset();
        pll_locked = 1'b1;
        repeat (500) @(posedge clock);
        #1;
        chk("glitch_hold", sys_reset, 1);
        @(negedge clock);
        pll_locked = 1'b0;
        @(negedge clock);
        lock_up("glitch_release");

`ifdef PLL_PHASE_SEQ_POS_EN
        do_reset();
        lock_up("pos_release");
        do_req(2'd1, 1'b1, 3, 0);
        do_req(2'd1, 1'b0, 5, 0);
        chk("phase_pos", phase_pos, 32'h0000_FE00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pll_phase_seq.md
Name: pll_phase_seq

Overview:
- Sequencer for the ECP5 EHXPLLL clock generator (CPU-cache, SDRAM, SDRAM-control and slow clocks) in the ULX3S builds.
- Synchronises the PLL lock signal and holds the design reset until lock has been stable for a set time.
- Executes dynamic phase-step requests (for SDRAM clock calibration) by driving PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG with correct pulse timing.
- Runs in the 25 MHz input-clock domain.

Parameters:
- LOCK_CYCLES, 1024, cycles of continuously synchronised lock required before reset release
- SETUP_CYCLES, 4, cycles sel/dir are held stable before the first pulse
- PULSE_CYCLES, 4, low width of each PHASESTEP/PHASELOADREG pulse
- SETTLE_CYCLES, 8, high time after each pulse
- STEP_W, 6, width of the step-count request

Ports:
- clock  in  1  input clock, 25 MHz
- reset  in  1  synchronous, active-high
- pll_locked  in  1  PLL LOCK, asynchronous
- req_valid  in  1  phase request valid
- req_ready  out  1  accept: high only in READY
- req_sel  in  2  PLL output select (0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3)
- req_dir  in  1  direction (1=lag, 0=lead)
- req_steps  in  STEP_W  number of steps, 0 allowed
- done  out  1  one-cycle completion pulse
- done_err  out  1  valid with done: request aborted by lock loss
- phasesel  out  2  to PLL PHASESEL[1:0]
- phasedir  out  1  to PLL PHASEDIR
- phasestep  out  1  to PLL PHASESTEP, idle high
- phaseloadreg  out  1  to PLL PHASELOADREG, idle high
- sys_reset  out  1  design reset, active-high
- lock_lost  out  1  sticky flag, cleared only by reset

Behaviour:
- Clocking and reset: one clock (clock). reset is synchronous and active-high.
- Reset values: state=LOCK_WAIT; sys_reset=1; phasestep=1; phaseloadreg=1; phasesel=0; phasedir=1; req_ready=0; done=0; done_err=0; lock_lost=0; all counters 0.
- pll_locked passes through a 2-flop synchroniser (lk_s). All lock decisions use lk_s, so there is 2 cycles of latency.
- LOCK_WAIT:
  - Counter increments while lk_s=1 and clears when lk_s=0.
  - When the counter reaches LOCK_CYCLES-1 with lk_s=1: sys_reset goes to 0 on the next cycle and the state moves to READY.
- READY: req_ready=1. A request is accepted when req_valid&req_ready. On acceptance, latch sel/dir/steps, drive phasesel/phasedir from the latched values, and go to SETUP.
- SETUP: hold for SETUP_CYCLES. Then:
  - if steps==0, go to LOAD_LO;
  - otherwise go to STEP_LO.
- STEP_LO: phasestep=0 for PULSE_CYCLES, then go to STEP_HI.
- STEP_HI: phasestep=1 for SETTLE_CYCLES, then decrement steps.
  - If steps are left, go to STEP_LO.
  - Otherwise go to LOAD_LO.
- LOAD_LO: phaseloadreg=0 for PULSE_CYCLES, then go to LOAD_HI.
- LOAD_HI: phaseloadreg=1 for SETTLE_CYCLES. Then pulse done=1, done_err=0, and go to READY.
- phasesel/phasedir stay constant from SETUP through LOAD_HI. They keep their last value in READY.
- Total request latency for N steps: 1 + SETUP + N*(PULSE+SETTLE) + PULSE + SETTLE cycles until done. With the defaults and N=0 this is 17 cycles.
- Lock loss (lk_s=0 in any state other than LOCK_WAIT):
  - Next cycle: sys_reset=1, lock_lost=1, phasestep=1, phaseloadreg=1, lock counter cleared, go to LOCK_WAIT.
  - If a request was in progress: done=1 and done_err=1 in that same cycle.
- Lock loss in the same cycle as request acceptance: lock loss wins, the request is not accepted, and req_ready is 0 on the next cycle.
- req_valid while not ready is ignored. There is no queueing; the requester holds req_valid.
- reset mid-operation: returns to the reset values immediately. A partial step sequence is abandoned with no done pulse.
- Step counter is STEP_W bits. req_steps at its maximum value (2^STEP_W-1) executes exactly that many pulses.

Optional Feature:
- Macro: PLL_PHASE_SEQ_POS_EN
- When defined:
  - Adds output phase_pos (4×8 bits, packed with output 0 in bits [7:0]): a signed net step count per PLL output.
  - Incremented per completed STEP_HI when dir=1, decremented when dir=0. Wraps modulo 256.
  - Cleared by reset. Not cleared by lock loss.
  - Steps completed before an abort remain counted.
- When not defined: the port and the counters are absent.

Decomposition:
- Package pll_phase_seq_pkg: state enum (LOCK_WAIT, READY, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI), output-select constants (SEL_CLKOP=0 … SEL_CLKOS3=3), and default timing constants.
- Sub-module lock_sync_filter: synchroniser plus stable-count qualifier.

Test Plan:
- Reset, then pll_locked=1 continuously → sys_reset falls exactly LOCK_CYCLES+2 cycles after the first high sample (1026). lock_lost=0.
- Lock glitch low for 1 cycle at count 500 → counter restarts; release occurs 1026 cycles after the glitch ends.
- Request sel=2, dir=1, steps=3 → phasesel=2, phasedir=1; exactly 3 phasestep low pulses, each 4 cycles, spaced 8 cycles high; then one 4-cycle phaseloadreg pulse; done after 1+4+36+12=53 cycles, done_err=0.
- Request steps=0 → no phasestep pulse; one phaseloadreg pulse; done at cycle 17.
- Drop pll_locked during the 2nd STEP_LO → done=1 with done_err=1; lock_lost=1; sys_reset=1; phasestep returns high; re-lock releases reset again after 1026 cycles.
- With PLL_PHASE_SEQ_POS_EN: 3 lag steps on sel 1, then 5 lead steps on sel 1 → phase_pos[15:8]=8'hFE (−2); other fields 0.
